// File: rtl/ddr3_phy_pkg.sv
// Shared types and constants for the DDR3 CS_N lane: nibble geometry,
// idle chip-select pattern and the delay-step sequencer state encoding.
package ddr3_phy_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] CS_N_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    DS_IDLE = 3'd0,
    DS_LOAD = 3'd1,
    DS_MOVE = 3'd2,
    DS_GAP  = 3'd3,
    DS_DONE = 3'd4
  } dly_state_t;

  // Limit a requested step count to the taps still available in that direction.
  function automatic logic [7:0] clamp_steps(input logic [7:0] steps, input logic [7:0] avail);
    return (steps > avail) ? avail : steps;
  endfunction

endpackage

// File: rtl/ddr3_cs_n_lane_ctrl_if.sv
// Fabric/IOD-facing signal bundle of the CS_N lane controller. The slave
// modport is the controller's view; master is the view of whoever drives it.
interface ddr3_cs_n_lane_ctrl_if;
  import ddr3_phy_pkg::*;

  logic                OUT_EN;
  logic                CMD_VALID;
  logic                CMD_READY;
  logic [1:0]          CMD_SLOT;
  logic [NIBBLE_W-1:0] TX_DATA_0;
  logic [NIBBLE_W-1:0] OE_DATA_0;
  logic                DLY_REQ_VALID;
  logic                DLY_REQ_READY;
  logic                DLY_REQ_LOAD;
  logic                DLY_REQ_DIR;
  logic [7:0]          DLY_REQ_STEPS;
  logic                DLY_DONE;
  logic                DLY_ERR;
  logic [7:0]          TAP_POS;
  logic                DELAY_LINE_MOVE_0;
  logic                DELAY_LINE_DIRECTION_0;
  logic                DELAY_LINE_LOAD_0;
  logic                DELAY_LINE_OUT_OF_RANGE_0;

  modport slave (
    input  OUT_EN, CMD_VALID, CMD_SLOT,
    input  DLY_REQ_VALID, DLY_REQ_LOAD, DLY_REQ_DIR, DLY_REQ_STEPS,
    input  DELAY_LINE_OUT_OF_RANGE_0,
    output CMD_READY, TX_DATA_0, OE_DATA_0,
    output DLY_REQ_READY, DLY_DONE, DLY_ERR, TAP_POS,
    output DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0
  );

  modport master (
    output OUT_EN, CMD_VALID, CMD_SLOT,
    output DLY_REQ_VALID, DLY_REQ_LOAD, DLY_REQ_DIR, DLY_REQ_STEPS,
    output DELAY_LINE_OUT_OF_RANGE_0,
    input  CMD_READY, TX_DATA_0, OE_DATA_0,
    input  DLY_REQ_READY, DLY_DONE, DLY_ERR, TAP_POS,
    input  DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0
  );

endinterface

// File: rtl/ddr3_dly_step_seq.sv
// Output delay-line training sequencer: turns one request into LOAD or a
// clamped, gap-spaced train of MOVE pulses and tracks the tap position.
module ddr3_dly_step_seq
  import ddr3_phy_pkg::*;
#(
  parameter int MAX_TAP  = 127,
  parameter int TAP_INIT = 1,
  parameter int STEP_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_i,
  input  logic       req_load_i,
  input  logic       req_dir_i,
  input  logic [7:0] req_steps_i,
  input  logic       oor_i,
  output logic       req_ready_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] tap_pos_o,
  output logic       move_o,
  output logic       dir_o,
  output logic       load_o
);

  localparam logic [2:0] S_IDLE = 3'(DS_IDLE);
  localparam logic [2:0] S_LOAD = 3'(DS_LOAD);
  localparam logic [2:0] S_MOVE = 3'(DS_MOVE);
  localparam logic [2:0] S_GAP  = 3'(DS_GAP);
  localparam logic [2:0] S_DONE = 3'(DS_DONE);

  localparam logic [7:0] MAX_TAP_W  = 8'(MAX_TAP);
  localparam logic [7:0] TAP_INIT_W = 8'(TAP_INIT);
  localparam logic [3:0] GAP_LAST   = 4'(STEP_GAP - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] tap_q, tap_d;
  logic [3:0] gap_q, gap_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;
  logic [7:0] avail;
  logic [7:0] clamped;

  assign avail   = req_dir_i ? (MAX_TAP_W - tap_q) : tap_q;
  assign clamped = clamp_steps(req_steps_i, avail);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    dir_d   = dir_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          dir_d = req_dir_i;
          err_d = 1'b0;
          gap_d = 4'd0;
          if (req_load_i) begin
            state_d = S_LOAD;
          end else begin
            rem_d   = clamped;
            err_d   = (clamped != req_steps_i);
            state_d = (clamped == 8'd0) ? S_DONE : S_MOVE;
          end
        end
      end
      S_LOAD: state_d = S_DONE;
      S_MOVE: begin
        rem_d = rem_q - 8'd1;
        gap_d = 4'd0;
        if (oor_i) begin
          err_d   = 1'b1;
          rem_d   = 8'd0;
          state_d = S_DONE;
        end else if (rem_q == 8'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (oor_i) begin
          err_d   = 1'b1;
          rem_d   = 8'd0;
          state_d = S_DONE;
        end else if (gap_q == GAP_LAST) begin
          gap_d   = 4'd0;
          state_d = S_MOVE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tap follows the state being entered so TAP_POS changes on the same edge
  // that raises MOVE or LOAD.
  always_comb begin
    tap_d = tap_q;
    if (state_d == S_MOVE) begin
      tap_d = dir_d ? (tap_q + 8'd1) : (tap_q - 8'd1);
    end else if (state_d == S_LOAD) begin
      tap_d = TAP_INIT_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= 8'd0;
      tap_q   <= TAP_INIT_W;
      gap_q   <= 4'd0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tap_q   <= tap_d;
      gap_q   <= gap_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign move_o      = (state_q == S_MOVE);
  assign load_o      = (state_q == S_LOAD);
  assign dir_o       = dir_q;
  assign err_o       = err_q;
  assign tap_pos_o   = tap_q;

endmodule

// File: rtl/ddr3_cs_n_lane_ctrl.sv
// Fabric-side driver for the DDR3 CS_N IOD lane: packs chip-select commands
// into the 4:1 TX/OE nibbles and hosts the delay-line step sequencer.
module ddr3_cs_n_lane_ctrl
  import ddr3_phy_pkg::*;
#(
  parameter int MAX_TAP  = 127,
  parameter int TAP_INIT = 1,
  parameter int STEP_GAP = 2
) (
  input logic                  FAB_CLK,
  input logic                  ARST_N,
  ddr3_cs_n_lane_ctrl_if.slave lane
);

  logic                ready_q;
  logic                accept;
  logic [NIBBLE_W-1:0] oe_q;
  logic [NIBBLE_W-1:0] tx_q;
  logic [NIBBLE_W-1:0] tx_d;

  assign accept = lane.CMD_VALID & ready_q;

  // Only the accepted slot drives CS_N low; bit 0 leaves the serialiser first.
  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_slot
      assign tx_d[gi] = ~(accept && (lane.CMD_SLOT == 2'(gi)));
    end
  endgenerate

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      ready_q <= 1'b0;
      oe_q    <= '0;
      tx_q    <= CS_N_IDLE;
    end else begin
      ready_q <= lane.OUT_EN;
      oe_q    <= {NIBBLE_W{lane.OUT_EN}};
      tx_q    <= tx_d;
    end
  end

  assign lane.CMD_READY = ready_q;
  assign lane.OE_DATA_0 = oe_q;
  assign lane.TX_DATA_0 = tx_q;

  ddr3_dly_step_seq #(
    .MAX_TAP  (MAX_TAP),
    .TAP_INIT (TAP_INIT),
    .STEP_GAP (STEP_GAP)
  ) u_step_seq (
    .clk         (FAB_CLK),
    .rst_n       (ARST_N),
    .req_valid_i (lane.DLY_REQ_VALID),
    .req_load_i  (lane.DLY_REQ_LOAD),
    .req_dir_i   (lane.DLY_REQ_DIR),
    .req_steps_i (lane.DLY_REQ_STEPS),
    .oor_i       (lane.DELAY_LINE_OUT_OF_RANGE_0),
    .req_ready_o (lane.DLY_REQ_READY),
    .done_o      (lane.DLY_DONE),
    .err_o       (lane.DLY_ERR),
    .tap_pos_o   (lane.TAP_POS),
    .move_o      (lane.DELAY_LINE_MOVE_0),
    .dir_o       (lane.DELAY_LINE_DIRECTION_0),
    .load_o      (lane.DELAY_LINE_LOAD_0)
  );

endmodule

// File: tb/tb_ddr3_cs_n_lane_ctrl.sv
// Directed bench for ddr3_cs_n_lane_ctrl: nibble scoreboard for the command
// path, expected MOVE/DONE cycle queues for the delay sequencer.
module tb_ddr3_cs_n_lane_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ddr3_cs_n_lane_ctrl_if bus ();

  ddr3_cs_n_lane_ctrl #(
    .MAX_TAP  (127),
    .TAP_INIT (1),
    .STEP_GAP (2)
  ) dut (
    .FAB_CLK (clk),
    .ARST_N  (rst_n),
    .lane    (bus)
  );

  logic [3:0] tx_sb[$];
  int         exp_move_q[$];
  int         exp_done_cyc;

  localparam int NCMD = 9;
  bit       oe_tab    [NCMD] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
  bit       valid_tab [NCMD] = '{1, 1, 0, 1, 1, 1, 0, 1, 1};
  bit [1:0] slot_tab  [NCMD] = '{0, 2, 1, 0, 1, 3, 2, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic ld, input logic dir, input logic [7:0] steps);
    chk("req_ready", 32'(bus.DLY_REQ_READY), 32'd1);
    bus.DLY_REQ_VALID = 1'b1;
    bus.DLY_REQ_LOAD  = ld;
    bus.DLY_REQ_DIR   = dir;
    bus.DLY_REQ_STEPS = steps;
  endtask

  // Cycle 1 is the first cycle after the accept edge.
  task automatic observe(input string tag, input int oor_cyc, input int exp_loads,
                         input logic exp_dir, input int tap_start);
    int cyc;
    int loads;
    int tap_e;
    bit got_done;
    cyc = 0; loads = 0; tap_e = tap_start; got_done = 1'b0;
    while (!got_done && cyc < 60) begin
      tick();
      cyc++;
      bus.DLY_REQ_VALID = 1'b0;
      bus.DELAY_LINE_OUT_OF_RANGE_0 = (cyc == oor_cyc);
      if (bus.DELAY_LINE_MOVE_0) begin
        if (exp_move_q.size() == 0) begin
          chk({tag, "_extra_move"}, 32'd1, 32'd0);
        end else begin
          chk({tag, "_move_cyc"}, 32'(cyc), 32'(exp_move_q.pop_front()));
        end
        tap_e = exp_dir ? tap_e + 1 : tap_e - 1;
        chk({tag, "_tap_at_move"}, 32'(bus.TAP_POS), 32'(tap_e));
        chk({tag, "_dir"}, 32'(bus.DELAY_LINE_DIRECTION_0), 32'(exp_dir));
      end
      if (bus.DELAY_LINE_LOAD_0) loads++;
      if (bus.DLY_DONE) begin
        got_done = 1'b1;
        chk({tag, "_done_cyc"}, 32'(cyc), 32'(exp_done_cyc));
      end
    end
    bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    chk({tag, "_missing_moves"}, 32'(exp_move_q.size()), 32'd0);
    chk({tag, "_loads"}, 32'(loads), 32'(exp_loads));
    exp_move_q.delete();
    tick();
    chk({tag, "_done_one_cycle"}, 32'(bus.DLY_DONE), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx"}, 32'(bus.TX_DATA_0), 32'hF);
    chk({tag, "_oe"}, 32'(bus.OE_DATA_0), 32'h0);
    chk({tag, "_cmd_ready"}, 32'(bus.CMD_READY), 32'd0);
    chk({tag, "_dly_ready"}, 32'(bus.DLY_REQ_READY), 32'd1);
    chk({tag, "_done"}, 32'(bus.DLY_DONE), 32'd0);
    chk({tag, "_err"}, 32'(bus.DLY_ERR), 32'd0);
    chk({tag, "_tap"}, 32'(bus.TAP_POS), 32'd1);
    chk({tag, "_move"}, 32'(bus.DELAY_LINE_MOVE_0), 32'd0);
    chk({tag, "_dir"}, 32'(bus.DELAY_LINE_DIRECTION_0), 32'd0);
    chk({tag, "_load"}, 32'(bus.DELAY_LINE_LOAD_0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_tx;
    logic       ready_m;
    int         stray;

    rst_n = 1'b0;
    bus.OUT_EN = 1'b0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_SLOT = 2'd0;
    bus.DLY_REQ_VALID = 1'b0;
    bus.DLY_REQ_LOAD = 1'b0;
    bus.DLY_REQ_DIR = 1'b0;
    bus.DLY_REQ_STEPS = 8'd0;
    bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Command path: OUT_EN rises with step 0, so READY only appears from step 1.
    ready_m = 1'b0;
    for (int i = 0; i < NCMD; i++) begin
      bus.OUT_EN    = oe_tab[i];
      bus.CMD_VALID = valid_tab[i];
      bus.CMD_SLOT  = slot_tab[i];
      chk("cmd_ready", 32'(bus.CMD_READY), 32'(ready_m));
      exp_tx = 4'hF;
      if (valid_tab[i] && ready_m) exp_tx[slot_tab[i]] = 1'b0;
      tx_sb.push_back(exp_tx);
      tick();
      chk("tx_nibble", 32'(bus.TX_DATA_0), 32'(tx_sb.pop_front()));
      chk("oe_nibble", 32'(bus.OE_DATA_0), {28'd0, {4{oe_tab[i]}}});
      ready_m = oe_tab[i];
    end
    bus.CMD_VALID = 1'b0;
    bus.OUT_EN = 1'b1;
    tick();
    chk("tx_idle_after_drop", 32'(bus.TX_DATA_0), 32'hF);
    tick();

    do_req(1'b0, 1'b1, 8'd3);
    exp_move_q = '{1, 4, 7};
    exp_done_cyc = 8;
    observe("inc3", 0, 0, 1'b1, 1);
    chk("inc3_tap", 32'(bus.TAP_POS), 32'd4);
    chk("inc3_err", 32'(bus.DLY_ERR), 32'd0);

    do_req(1'b0, 1'b0, 8'd10);
    exp_move_q = '{1, 4, 7, 10};
    exp_done_cyc = 11;
    observe("dec10", 0, 0, 1'b0, 4);
    chk("dec10_tap", 32'(bus.TAP_POS), 32'd0);
    chk("dec10_err", 32'(bus.DLY_ERR), 32'd1);

    do_req(1'b0, 1'b0, 8'd2);
    exp_done_cyc = 1;
    observe("dec_at_zero", 0, 0, 1'b0, 0);
    chk("dec_at_zero_tap", 32'(bus.TAP_POS), 32'd0);
    chk("dec_at_zero_err", 32'(bus.DLY_ERR), 32'd1);

    do_req(1'b0, 1'b1, 8'd0);
    exp_done_cyc = 1;
    observe("steps0", 0, 0, 1'b1, 0);
    chk("steps0_err_cleared", 32'(bus.DLY_ERR), 32'd0);

    do_req(1'b1, 1'b0, 8'd9);
    exp_done_cyc = 2;
    observe("load", 0, 1, 1'b0, 0);
    chk("load_tap", 32'(bus.TAP_POS), 32'd1);
    chk("load_err", 32'(bus.DLY_ERR), 32'd0);

    do_req(1'b0, 1'b1, 8'd5);
    exp_move_q = '{1, 4};
    exp_done_cyc = 6;
    observe("oor", 5, 0, 1'b1, 1);
    chk("oor_tap", 32'(bus.TAP_POS), 32'd3);
    chk("oor_err", 32'(bus.DLY_ERR), 32'd1);

    // Asynchronous reset while MOVE is high and commands are streaming.
    do_req(1'b0, 1'b1, 8'd5);
    bus.CMD_VALID = 1'b1;
    bus.CMD_SLOT = 2'd1;
    tick();
    bus.DLY_REQ_VALID = 1'b0;
    chk("pre_rst_move1", 32'(bus.DELAY_LINE_MOVE_0), 32'd1);
    tick();
    tick();
    tick();
    chk("pre_rst_move2", 32'(bus.DELAY_LINE_MOVE_0), 32'd1);
    chk("pre_rst_tx", 32'(bus.TX_DATA_0), 32'hD);
    chk("pre_rst_tap", 32'(bus.TAP_POS), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    bus.CMD_VALID = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.DELAY_LINE_MOVE_0) stray++;
    end
    chk("post_rst_no_move", 32'(stray), 32'd0);
    chk("post_rst_tap", 32'(bus.TAP_POS), 32'd1);

    do_req(1'b0, 1'b1, 8'd1);
    exp_move_q = '{1};
    exp_done_cyc = 2;
    observe("post_rst_req", 0, 0, 1'b1, 1);
    chk("post_rst_req_tap", 32'(bus.TAP_POS), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
